arm_code_drain: RTL and testbench
=================================

Name: arm_code_drain

Overview:
Draining end of the accelerator's ARM-instruction output path. The translator state machine pushes 32-bit ARM words using the same start/ready handshake it uses toward the output RAM writer. This block buffers those words in a circular word store. It streams them out byte-serially, little-endian, to the host/loader over a valid/ack byte interface. It is the reader counterpart to the instruction writer and the mirror image of the input-side byte generator: bytes leave the accelerator instead of entering it.

Parameters:
- DEPTH, 16, number of 32-bit words buffered; must be a power of two.
- ADDR_W, 4, log2(DEPTH); pointer width excluding the wrap bit.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  word-write request from the translator; sampled on the rising edge.
- data  input  32  ARM instruction word; captured when start && ready.
- ready  output  1  high when the store can accept a word (not full).
- out_byte  output  8  current instruction byte to the host.
- out_valid  output  1  out_byte holds a valid byte.
- out_ack  input  1  host consumes out_byte on the rising edge when out_valid && out_ack.
- level  output  ADDR_W+1  number of whole words held in the store, excluding the word being serialized.
- words_sent  output  16  count of words fully emitted; wraps modulo 2^16.
- overflow  output  1  sticky flag: a start arrived while ready was low.

Behaviour:
- Reset values (asynchronous, while reset is high):
  - write and read pointers = 0; FSM = IDLE.
  - out_valid = 0, out_byte = 0x00, ready = 1, level = 0, words_sent = 0, overflow = 0.
- Pointers:
  - Write and read pointers are ADDR_W+1 bits; the MSB is the wrap bit.
  - Empty: pointers equal.
  - Full: low bits equal and MSBs differ.
  - level = wptr - rptr, modulo 2^(ADDR_W+1).
- Write side:
  - ready = !full, decoded from registered pointers; there is no same-cycle bypass from a read.
  - start && ready: mem[wptr[ADDR_W-1:0]] <= data; wptr++.
  - start && !ready: the word is dropped, pointers are unchanged, and overflow is set to 1 until reset.
- Read FSM, states IDLE, LOAD, SEND:
  - IDLE: out_valid = 0. If not empty, go to LOAD next cycle.
  - LOAD: shift <= mem[rptr]; rptr++; byte_idx <= 0; go to SEND. out_valid stays 0 in this cycle.
  - SEND: out_valid = 1; out_byte = shift[7:0].
    - Without ack: out_byte and out_valid hold stable.
    - On ack with byte_idx < 3: shift >>= 8; byte_idx++.
    - On ack with byte_idx == 3: words_sent++. Next state is LOAD if not empty (evaluated on registered pointers this cycle), otherwise IDLE.
- Byte order: byte 0 = data[7:0], byte 3 = data[31:24].
- Latency:
  - Word accepted at edge N into an empty, idle block: FSM enters LOAD at edge N+1 and SEND at edge N+2; out_valid is high after edge N+2.
  - Back-to-back words with ack held high: one idle (LOAD) cycle between words, so 4 bytes per 5 cycles.
- Simultaneous write and LOAD in the same cycle are both honoured. level is unchanged by that cycle.
- A write while full is refused even if LOAD frees a slot in the same cycle; ready rises the following cycle.
- Reset mid-operation: discards all buffered words and any partially sent word. No further bytes are emitted for them. overflow and words_sent clear.
- out_ack while out_valid is low is ignored.

Test Plan:
- Single word: one start with data=0xE52D0004 and out_ack held 1 → out_valid rises 2 cycles after the write edge; bytes 0x04, 0x00, 0x2D, 0xE5 on consecutive cycles; words_sent=1; FSM returns to IDLE; level=0.
- Backpressure: write 0xE3400012 with out_ack=0 for 5 cycles → out_byte stays 0x12 with out_valid=1. Then ack every other cycle → 0x00, 0x40, 0xE3 each held until acked.
- Full/overflow: with out_ack=0, issue 18 consecutive starts with data=0..17.
  - Word 0 goes to the shift register; the next 16 fill the store: level=16, ready=0.
  - The 18th start (data 17) sets overflow=1 and is not stored.
  - Drain all → exactly 17 words, values 0..16, in order.
- Concurrent traffic: write a new word every 3 cycles while acking continuously for 40 cycles → byte stream equals the LE concatenation of all words in order, with no loss or duplication, and words_sent matches the write count.
- Reset mid-word: after 2 bytes of 0xAABBCCDD are acked with 3 more words queued, pulse reset → outputs return to reset values immediately. After release with no writes, out_valid stays 0 for 10 cycles.
- Pointer wrap: push and drain 40 words one at a time (DEPTH=16) → correct data across two pointer wraps; level returns to 0.

Source files
------------

// File: rtl/arm_code_drain_if.sv
// Handshake bundle for the ARM-word drain: word-write side from the translator
// and byte-serial output side toward the host/loader.
interface arm_code_drain_if;
    logic        start;
    logic [31:0] data;
    logic        ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ack;

    modport master (
        output start,
        output data,
        input  ready,
        input  out_byte,
        input  out_valid,
        output out_ack
    );

    modport slave (
        input  start,
        input  data,
        output ready,
        output out_byte,
        output out_valid,
        input  out_ack
    );
endinterface

// File: rtl/arm_code_drain.sv
// Buffers 32-bit ARM words in a circular store and streams them out
// little-endian, one byte per valid/ack transfer.
module arm_code_drain #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    arm_code_drain_if.slave   bus,
    output logic [ADDR_W:0]   level,
    output logic [15:0]       words_sent,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W:0]   wptr_r;
    logic [ADDR_W:0]   rptr_r;
    logic [31:0]       mem_r [DEPTH];
    logic [31:0]       shift_r;
    logic [1:0]        byte_idx_r;
    logic [15:0]       words_sent_r;
    logic              overflow_r;
    logic              out_valid_r;
    logic              empty_s;
    logic              full_s;
    logic              write_s;
    logic              byte_ack_s;

    // Full when the low bits match but the wrap bits differ.
    assign empty_s    = (wptr_r == rptr_r);
    assign full_s     = (wptr_r[ADDR_W] != rptr_r[ADDR_W]) &&
                        (wptr_r[ADDR_W-1:0] == rptr_r[ADDR_W-1:0]);
    assign write_s    = bus.start && !full_s;
    assign byte_ack_s = (state_r == SEND) && bus.out_ack;

    assign bus.ready     = !full_s;
    assign bus.out_byte  = shift_r[7:0];
    assign bus.out_valid = out_valid_r;
    assign level         = wptr_r - rptr_r;
    assign words_sent    = words_sent_r;
    assign overflow      = overflow_r;

    // Read FSM next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                state_next_s = SEND;
            end
            SEND: begin
                if (byte_ack_s && (byte_idx_r == 2'd3)) begin
                    if (!empty_s) begin
                        state_next_s = LOAD;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = SEND;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register; out_valid is registered alongside it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            out_valid_r <= (state_next_s == SEND);
        end
    end

    // Write pointer and sticky overflow; a refused word leaves pointers alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_r     <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (write_s) begin
                wptr_r <= wptr_r + (ADDR_W+1)'(1);
            end
            if (bus.start && full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Word store; contents need no reset since pointers gate every read.
    always_ff @(posedge clk) begin
        if (write_s) begin
            mem_r[wptr_r[ADDR_W-1:0]] <= bus.data;
        end
    end

    // Read pointer, byte serializer and sent-word counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rptr_r       <= '0;
            shift_r      <= 32'h0000_0000;
            byte_idx_r   <= 2'd0;
            words_sent_r <= 16'd0;
        end else begin
            case (state_r)
                LOAD: begin
                    shift_r    <= mem_r[rptr_r[ADDR_W-1:0]];
                    rptr_r     <= rptr_r + (ADDR_W+1)'(1);
                    byte_idx_r <= 2'd0;
                end
                SEND: begin
                    if (byte_ack_s) begin
                        if (byte_idx_r == 2'd3) begin
                            words_sent_r <= words_sent_r + 16'd1;
                        end else begin
                            shift_r    <= {8'h00, shift_r[31:8]};
                            byte_idx_r <= byte_idx_r + 2'd1;
                        end
                    end
                end
                default: begin
                    byte_idx_r <= byte_idx_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arm_code_drain.sv
// Directed bench for arm_code_drain: latency, backpressure, full/overflow,
// concurrent streaming, mid-word reset and pointer wrap.
module tb_arm_code_drain;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  level;
    logic [15:0] words_sent;
    logic        overflow;

    int          n_total = 0;
    int          n_pass  = 0;
    int          extra_bytes = 0;
    bit          mon_en = 1'b0;
    logic [7:0]  exp_q [$];

    arm_code_drain_if bus ();

    arm_code_drain #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .level      (level),
        .words_sent (words_sent),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        bus.start = 1'b1;
        bus.data  = w;
        step();
        bus.start = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] w);
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[31:24]);
    endtask

    // Stream scoreboard: every accepted byte must match the next expected one.
    always @(posedge clk) begin
        if (mon_en && bus.out_valid && bus.out_ack) begin
            if (exp_q.size() == 0) begin
                extra_bytes++;
            end else begin
                check("stream_byte", {24'h0, bus.out_byte}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        logic [7:0] bp_bytes [4];
        int         budget;
        bit         seen_valid;

        bus.start   = 1'b0;
        bus.data    = 32'h0000_0000;
        bus.out_ack = 1'b0;
        reset       = 1'b1;
        repeat (2) step();

        check("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
        check("rst_out_byte", {24'h0, bus.out_byte}, 32'h00);
        check("rst_ready", {31'h0, bus.ready}, 32'd1);
        check("rst_level", {27'h0, level}, 32'd0);
        check("rst_words_sent", {16'h0, words_sent}, 32'd0);
        check("rst_overflow", {31'h0, overflow}, 32'd0);
        reset = 1'b0;
        step();

        // Single word with ack held: two-cycle latency, then four bytes.
        bus.out_ack = 1'b1;
        push_word(32'hE52D_0004);
        check("sw_valid_n", {31'h0, bus.out_valid}, 32'd0);
        check("sw_level_n", {27'h0, level}, 32'd1);
        step();
        check("sw_valid_load", {31'h0, bus.out_valid}, 32'd0);
        step();
        check("sw_valid_send", {31'h0, bus.out_valid}, 32'd1);
        check("sw_byte0", {24'h0, bus.out_byte}, 32'h04);
        check("sw_level_send", {27'h0, level}, 32'd0);
        step();
        check("sw_byte1", {24'h0, bus.out_byte}, 32'h00);
        step();
        check("sw_byte2", {24'h0, bus.out_byte}, 32'h2D);
        step();
        check("sw_byte3", {24'h0, bus.out_byte}, 32'hE5);
        step();
        check("sw_idle_valid", {31'h0, bus.out_valid}, 32'd0);
        check("sw_words_sent", {16'h0, words_sent}, 32'd1);
        check("sw_level_end", {27'h0, level}, 32'd0);

        // Backpressure: hold byte 0 without ack, then ack every other cycle.
        bus.out_ack = 1'b0;
        push_word(32'hE340_0012);
        repeat (2) step();
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", {31'h0, bus.out_valid}, 32'd1);
            check("bp_hold_byte", {24'h0, bus.out_byte}, 32'h12);
            step();
        end
        bp_bytes[0] = 8'h12; bp_bytes[1] = 8'h00; bp_bytes[2] = 8'h40; bp_bytes[3] = 8'hE3;
        for (int k = 1; k < 4; k++) begin
            bus.out_ack = 1'b1;
            step();
            bus.out_ack = 1'b0;
            check("bp_next_byte", {24'h0, bus.out_byte}, {24'h0, bp_bytes[k]});
            step();
            check("bp_held_byte", {24'h0, bus.out_byte}, {24'h0, bp_bytes[k]});
        end
        bus.out_ack = 1'b1;
        step();
        bus.out_ack = 1'b0;
        check("bp_done_valid", {31'h0, bus.out_valid}, 32'd0);
        check("bp_words_sent", {16'h0, words_sent}, 32'd2);

        // Full store: 18 starts, the last one refused.
        for (int i = 0; i < 18; i++) begin
            push_word(32'(i));
        end
        check("full_level", {27'h0, level}, 32'd16);
        check("full_ready", {31'h0, bus.ready}, 32'd0);
        check("full_overflow", {31'h0, overflow}, 32'd1);
        for (int i = 0; i < 17; i++) begin
            push_exp(32'(i));
        end
        mon_en = 1'b1;
        bus.out_ack = 1'b1;
        budget = 0;
        while (words_sent != 16'd19 && budget < 200) begin
            step();
            budget++;
        end
        step();
        check("full_words_sent", {16'h0, words_sent}, 32'd19);
        check("full_level_end", {27'h0, level}, 32'd0);
        check("full_ready_end", {31'h0, bus.ready}, 32'd1);
        check("full_drained", 32'(exp_q.size()), 32'd0);

        // Concurrent writes every third cycle while acking continuously.
        for (int c = 0; c < 40; c++) begin
            if (c % 3 == 0) begin
                bus.start = 1'b1;
                bus.data  = 32'h1020_3040 + 32'(c) * 32'h0101_0101;
                push_exp(bus.data);
            end else begin
                bus.start = 1'b0;
            end
            step();
        end
        bus.start = 1'b0;
        budget = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && budget < 200) begin
            step();
            budget++;
        end
        check("conc_words_sent", {16'h0, words_sent}, 32'd33);
        check("conc_drained", 32'(exp_q.size()), 32'd0);
        check("conc_overflow_sticky", {31'h0, overflow}, 32'd1);

        // Reset in the middle of a word with more words queued.
        mon_en = 1'b0;
        bus.out_ack = 1'b0;
        push_word(32'hAABB_CCDD);
        push_word(32'h1111_1111);
        push_word(32'h2222_2222);
        push_word(32'h3333_3333);
        bus.out_ack = 1'b1;
        repeat (2) step();
        bus.out_ack = 1'b0;
        check("mid_byte2", {24'h0, bus.out_byte}, 32'hBB);
        check("mid_level", {27'h0, level}, 32'd3);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'h0, bus.out_valid}, 32'd0);
        check("mid_rst_byte", {24'h0, bus.out_byte}, 32'h00);
        check("mid_rst_ready", {31'h0, bus.ready}, 32'd1);
        check("mid_rst_level", {27'h0, level}, 32'd0);
        check("mid_rst_words_sent", {16'h0, words_sent}, 32'd0);
        check("mid_rst_overflow", {31'h0, overflow}, 32'd0);
        step();
        reset = 1'b0;
        bus.out_ack = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.out_valid) seen_valid = 1'b1;
        end
        check("mid_quiet", {31'h0, seen_valid}, 32'd0);

        // Pointer wrap: 40 words pushed and drained one at a time.
        exp_q.delete();
        extra_bytes = 0;
        mon_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push_exp(32'hC0DE_0000 + 32'(i) * 32'h0003_0105);
            push_word(32'hC0DE_0000 + 32'(i) * 32'h0003_0105);
            budget = 0;
            while (words_sent != 16'(i + 1) && budget < 20) begin
                step();
                budget++;
            end
        end
        step();
        check("wrap_words_sent", {16'h0, words_sent}, 32'd40);
        check("wrap_level", {27'h0, level}, 32'd0);
        check("wrap_drained", 32'(exp_q.size()), 32'd0);
        check("no_extra_bytes", 32'(extra_bytes), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
